t9990_blit_scan: RTL

//  Rectangle walker for the blitter. Steps X/Y over an NX x NY block, drives
//  T9990_BLIT_ADDR, and issues one memory request per pixel with a REQ/ACK

---
 rtl/t9990_blit_scan.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/t9990_blit_scan.sv
// t9990_blit_scan: rectangle walker for the blitter.
// Walks X/Y over an NX x NY block and issues one REQ/ACK memory request per
// pixel. X/Y go to the address unit; ADDR_IN comes back ADDR_LAT cycles later
// and is forwarded on MEM_ADDR while MEM_REQ is high.
// Ports:
//   CLK, RESET_n          clock, asynchronous active-low reset
//   START, ABORT          scan start pulse / scan abort
//   SX, SY, NX, NY        start position and block size (0 = max size)
//   DIX, DIY              X/Y step direction (1 = decrement)
//   XIMM, CLRM            image width select, colour mode
//   X, Y                  current position to address unit
//   ADDR_IN               word address from address unit
//   MEM_REQ/ADDR/PIX/ACK  memory request handshake
//   BUSY, DONE            scan status, end-of-scan pulse
module t9990_blit_scan #(
    parameter int unsigned ADDR_LAT = 1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        START,
    input  logic        ABORT,
    input  logic [10:0] SX,
    input  logic [11:0] SY,
    input  logic [10:0] NX,
    input  logic [11:0] NY,
    input  logic        DIX,
    input  logic        DIY,
    input  logic [1:0]  XIMM,
    input  logic [1:0]  CLRM,
    output logic [10:0] X,
    output logic [11:0] Y,
    input  logic [18:0] ADDR_IN,
    output logic        MEM_REQ,
    output logic [18:0] MEM_ADDR,
    output logic [3:0]  MEM_PIX,
    input  logic        MEM_ACK,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned XW  = 11;
    localparam int unsigned YW  = 12;
    localparam int unsigned XCW = 12;
    localparam int unsigned YCW = 13;
    localparam int unsigned LW  = (ADDR_LAT > 1) ? $clog2(ADDR_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, sx_q, sx_d;
    logic [YW-1:0]   y_q, y_d;
    logic [XCW-1:0]  xcnt_q, xcnt_d, nx_q, nx_d;
    logic [YCW-1:0]  ycnt_q, ycnt_d;
    logic            dix_q, dix_d, diy_q, diy_d;
    logic [1:0]      ximm_q, ximm_d, clrm_q, clrm_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]      pix_q, pix_d;

    // Keeps X inside the selected image width (256/512/1024/2048).
    function automatic logic [XW-1:0] xmask(input logic [1:0] ximm);
        return {ximm == 2'd3, ximm[1], ximm != 2'd0, 8'hFF};
    endfunction

    // Pixel index within the memory word for the given colour mode.
    function automatic logic [3:0] pix_of(input logic [XW-1:0] x, input logic [1:0] clrm);
        logic [3:0] p;
        case (clrm)
            2'd0:    p = x[3:0];
            2'd1:    p = {1'b0, x[2:0]};
            2'd2:    p = {2'b00, x[1:0]};
            default: p = {3'b000, x[0]};
        endcase
        return p;
    endfunction

    // Next-state and next-register computation.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        nx_d    = nx_q;
        xcnt_d  = xcnt_q;
        ycnt_d  = ycnt_q;
        dix_d   = dix_q;
        diy_d   = diy_q;
        ximm_d  = ximm_q;
        clrm_d  = clrm_q;
        lat_d   = lat_q;
        busy_d  = busy_q;
        req_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    x_d     = SX & xmask(XIMM);
                    sx_d    = SX & xmask(XIMM);
                    y_d     = SY;
                    xcnt_d  = (NX == '0) ? XCW'(2048) : XCW'(NX);
                    nx_d    = (NX == '0) ? XCW'(2048) : XCW'(NX);
                    ycnt_d  = (NY == '0) ? YCW'(4096) : YCW'(NY);
                    dix_d   = DIX;
                    diy_d   = DIY;
                    ximm_d  = XIMM;
                    clrm_d  = CLRM;
                    lat_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Give the address unit ADDR_LAT cycles to produce ADDR_IN.
                if (lat_q == LW'(ADDR_LAT - 1)) begin
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else begin
                    lat_d = LW'(lat_q + 1'b1);
                end
            end
            S_REQ: begin
                req_d = 1'b1;
                if (MEM_ACK) begin
                    req_d = 1'b0;
                    lat_d = '0;
                    if (xcnt_q > XCW'(1)) begin
                        x_d     = (dix_q ? x_q - XW'(1) : x_q + XW'(1)) & xmask(ximm_q);
                        xcnt_d  = xcnt_q - XCW'(1);
                        state_d = S_WAIT;
                    end else if (ycnt_q > YCW'(1)) begin
                        x_d     = sx_q;
                        xcnt_d  = nx_q;
                        y_d     = diy_q ? y_q - YW'(1) : y_q + YW'(1);
                        ycnt_d  = ycnt_q - YCW'(1);
                        state_d = S_WAIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything from any active state.
        if (ABORT && state_q != S_IDLE) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end

        pix_d = pix_of(x_d, clrm_d);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= '0;
            nx_q    <= '0;
            xcnt_q  <= '0;
            ycnt_q  <= '0;
            dix_q   <= 1'b0;
            diy_q   <= 1'b0;
            ximm_q  <= '0;
            clrm_q  <= '0;
            lat_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= sx_d;
            nx_q    <= nx_d;
            xcnt_q  <= xcnt_d;
            ycnt_q  <= ycnt_d;
            dix_q   <= dix_d;
            diy_q   <= diy_d;
            ximm_q  <= ximm_d;
            clrm_q  <= clrm_d;
            lat_q   <= lat_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
        end
    end

    assign X        = x_q;
    assign Y        = y_q;
    assign MEM_REQ  = req_q;
    assign MEM_PIX  = pix_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    // ADDR_IN is already aligned to X/Y when REQ is entered; pass it straight through.
    assign MEM_ADDR = req_q ? ADDR_IN : '0;

endmodule
